// File: rtl/alu_sequencer.sv
// RV32I ALU-instruction sequencer: IDLE/DECODE/EXEC/WB FSM
// driving an external combinational ALU, with a 32x32 register file.
module alu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] F7_Z  = 7'b0000000;
  localparam logic [6:0] F7_A  = 7'b0100000;

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic            is_r;
  logic            is_i;
  logic            f7_zero;
  logic            f7_alt;
  logic            is_shift;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [3:0]      base_op;
  logic            dec_legal;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            run;

  assign opcode   = instr_q[6:0];
  assign rd       = instr_q[11:7];
  assign funct3   = instr_q[14:12];
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign funct7   = instr_q[31:25];
  assign is_r     = opcode == OPC_R;
  assign is_i     = opcode == OPC_I;
  assign f7_zero  = funct7 == F7_Z;
  assign f7_alt   = funct7 == F7_A;
  assign is_shift = funct3 == 3'b001 ||
                    funct3 == 3'b101;
  assign run      = !reset;

  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  always_comb begin
    base_op = OP_ADD;
    unique case (funct3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = base_op;
    unique case (1'b1)
      is_r: begin
        unique case (funct3)
          3'b000: begin
            dec_legal = f7_zero | f7_alt;
            if (f7_alt) dec_op = OP_SUB;
          end
          3'b101: begin
            dec_legal = f7_zero | f7_alt;
            if (f7_alt) dec_op = OP_SRA;
          end
          default: dec_legal = f7_zero;
        endcase
      end
      is_i: begin
        // upper immediate bits only act as funct7 on shifts
        unique case (funct3)
          3'b001: dec_legal = f7_zero;
          3'b101: begin
            dec_legal = f7_zero | f7_alt;
            if (f7_alt) dec_op = OP_SRA;
          end
          default: dec_legal = 1'b1;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    dec_a = rs1_val;
    dec_b = rs2_val;
    if (is_i) begin
      if (is_shift)
        dec_b = {{(XLEN-5){1'b0}}, instr_q[24:20]};
      else
        dec_b = {{(XLEN-12){instr_q[31]}},
                 instr_q[31:20]};
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    rf_d    = rf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_legal) begin
          a_d     = dec_a;
          b_d     = dec_b;
          op_d    = dec_op;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        state_d = WB;
      end
      default: begin
        if (rd != 5'd0) rf_d[rd] = res_q;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      for (int i = 0; i < 32; i++)
        rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      rf_q    <= rf_d;
    end
  end

  always_comb begin
    in_ready = run && state_q == IDLE;
    alu_req  = run && state_q == EXEC;
    wb_valid = run && state_q == WB;
    illegal  = run && state_q == DECODE &&
               !dec_legal;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    wb_rd    = '0;
    wb_data  = '0;
    if (alu_req) begin
      alu_a  = a_q;
      alu_b  = b_q;
      alu_op = op_q;
    end
    if (wb_valid) begin
      wb_rd   = rd;
      wb_data = res_q;
    end
  end

  assign dbg_data = (dbg_addr == 5'd0) ? '0
                                       : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with an
// instruction-level reference model and directed anchor cases.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .alu_req    (alu_req),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  function automatic logic [31:0] alu_f(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op
  );
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return {31'd0, $signed(a) < $signed(b)};
      4'd4: return {31'd0, a < b};
      4'd5: return a ^ b;
      4'd6: return a >> b[4:0];
      4'd7: return $signed(a) >>> b[4:0];
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  function automatic bit f_legal(input logic [31:0] ins);
    logic [6:0] opc;
    logic [2:0] f3;
    bit z;
    bit alt;
    opc = ins[6:0];
    f3  = ins[14:12];
    z   = ins[31:25] == 7'h00;
    alt = ins[31:25] == 7'h20;
    if (opc == 7'h33)
      return (f3 == 3'd0 || f3 == 3'd5) ? (z || alt) : z;
    if (opc == 7'h13) begin
      if (f3 == 3'd1) return z;
      if (f3 == 3'd5) return z || alt;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] f_op(input logic [31:0] ins);
    logic [3:0] tbl [8];
    logic [3:0] op;
    bit alt;
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    alt = ins[31:25] == 7'h20;
    op  = tbl[ins[14:12]];
    if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && alt)
      op = 4'd1;
    if (ins[14:12] == 3'd5 && alt)
      op = 4'd7;
    return op;
  endfunction

  function automatic logic [31:0] f_b(
    input logic [31:0] ins,
    input logic [31:0] rs2v
  );
    if (ins[6:0] == 7'h33) return rs2v;
    if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)
      return {27'd0, ins[24:20]};
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  // Reference model: age counts cycles since acceptance, -1 = idle.
  int          age = -1;
  logic [31:0] cur = '0;
  bit          cur_legal = 1'b0;
  logic [3:0]  cur_op = '0;
  logic [31:0] cur_a = '0;
  logic [31:0] cur_b = '0;
  logic [31:0] ref_rf [32] = '{default: '0};

  always @(posedge clk) begin
    if (reset) begin
      age <= -1;
      for (int i = 0; i < 32; i++) ref_rf[i] <= '0;
    end else begin
      case (age)
        -1: if (in_valid) begin
          cur       <= in_instr;
          cur_legal <= f_legal(in_instr);
          cur_op    <= f_op(in_instr);
          cur_a     <= ref_rf[in_instr[19:15]];
          cur_b     <= f_b(in_instr, ref_rf[in_instr[24:20]]);
          age       <= 1;
        end
        1: age <= cur_legal ? 2 : -1;
        2: age <= 3;
        default: begin
          if (cur[11:7] != 5'd0)
            ref_rf[cur[11:7]] <= alu_f(cur_a, cur_b, cur_op);
          age <= -1;
        end
      endcase
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  int          wb_cnt = 0;
  int          ill_cnt = 0;
  int          ready_cnt = 0;
  logic [31:0] last_wb_data = '0;
  logic [4:0]  last_wb_rd = '0;
  logic [31:0] last_alu_a = '0;
  logic [31:0] last_alu_b = '0;
  logic [3:0]  last_alu_op = '0;

  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready},
        {31'd0, !reset && age == -1});
    chk("alu_req", {31'd0, alu_req},
        {31'd0, !reset && age == 2});
    chk("alu_a", alu_a, (!reset && age == 2) ? cur_a : 32'd0);
    chk("alu_b", alu_b, (!reset && age == 2) ? cur_b : 32'd0);
    chk("alu_op", {28'd0, alu_op},
        (!reset && age == 2) ? {28'd0, cur_op} : 32'd0);
    chk("wb_valid", {31'd0, wb_valid},
        {31'd0, !reset && age == 3});
    chk("wb_rd", {27'd0, wb_rd},
        (!reset && age == 3) ? {27'd0, cur[11:7]} : 32'd0);
    chk("wb_data", wb_data,
        (!reset && age == 3) ? alu_f(cur_a, cur_b, cur_op) : 32'd0);
    chk("illegal", {31'd0, illegal},
        {31'd0, !reset && age == 1 && !cur_legal});
    chk("dbg_data", dbg_data, ref_rf[dbg_addr]);
    if (wb_valid) begin
      wb_cnt       <= wb_cnt + 1;
      last_wb_data <= wb_data;
      last_wb_rd   <= wb_rd;
    end
    if (alu_req) begin
      last_alu_a  <= alu_a;
      last_alu_b  <= alu_b;
      last_alu_op <= alu_op;
    end
    if (illegal) ill_cnt <= ill_cnt + 1;
    if (in_ready) ready_cnt <= ready_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    dbg_addr = 5'($urandom);
  endtask

  task automatic issue(input logic [31:0] ins);
    int n;
    n = 0;
    while (age != -1 && n < 20) begin
      tick();
      n++;
    end
    if (age != -1) begin
      err_cnt++;
      cmp_cnt++;
      $display("FAIL issue_timeout: got busy expected idle");
    end
    in_valid = 1'b1;
    in_instr = ins;
    tick();
    in_valid = 1'b0;
    in_instr = $urandom;
  endtask

  function automatic logic [31:0] rand_instr();
    int r;
    int s;
    logic [6:0] opc;
    logic [6:0] f7;
    r   = $urandom_range(0, 9);
    opc = r < 4 ? 7'h33 : (r < 8 ? 7'h13 : 7'($urandom));
    s   = $urandom_range(0, 3);
    f7  = s < 2 ? 7'h00 : (s == 2 ? 7'h20 : 7'($urandom));
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom),
            5'($urandom), opc};
  endfunction

  function automatic logic [31:0] legal_instr();
    if ($urandom_range(0, 1) == 0)
      return {7'h00, 5'($urandom), 5'($urandom), 3'($urandom),
              5'($urandom), 7'h33};
    return {12'($urandom), 5'($urandom), 3'd0,
            5'($urandom), 7'h13};
  endfunction

  int wb0;
  int ill0;
  int rdy0;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    issue(32'h00500093);
    repeat (3) tick();
    chk("addi_x1_data", last_wb_data, 32'd5);
    chk("addi_x1_rd", {27'd0, last_wb_rd}, 32'd1);

    issue(32'hFFD00113);
    repeat (3) tick();
    chk("addi_x2_data", last_wb_data, 32'hFFFFFFFD);
    chk("model_x2", ref_rf[2], 32'hFFFFFFFD);
    dbg_addr = 5'd2;
    #1;
    chk("dbg_x2", dbg_data, 32'hFFFFFFFD);

    issue(32'h402081B3);
    repeat (3) tick();
    chk("sub_op", {28'd0, last_alu_op}, 32'd1);
    chk("sub_a", last_alu_a, 32'd5);
    chk("sub_b", last_alu_b, 32'hFFFFFFFD);
    chk("sub_rd", {27'd0, last_wb_rd}, 32'd3);
    chk("sub_data", last_wb_data, 32'd8);

    issue(32'h40115213);
    repeat (3) tick();
    chk("srai_op", {28'd0, last_alu_op}, 32'd7);
    chk("srai_b", last_alu_b, 32'd1);
    chk("srai_data", last_wb_data, 32'hFFFFFFFE);

    wb0  = wb_cnt;
    ill0 = ill_cnt;
    issue(32'h40111213);
    repeat (3) tick();
    chk("slli_bad_illegal", ill_cnt - ill0, 32'd1);
    chk("slli_bad_no_wb", wb_cnt - wb0, 32'd0);
    dbg_addr = 5'd2;
    #1;
    chk("slli_bad_x2", dbg_data, 32'hFFFFFFFD);

    issue(32'h00700013);
    repeat (3) tick();
    chk("x0_rd", {27'd0, last_wb_rd}, 32'd0);
    chk("x0_data", last_wb_data, 32'd7);
    dbg_addr = 5'd0;
    #1;
    chk("dbg_x0", dbg_data, 32'd0);

    tick();
    wb0  = wb_cnt;
    rdy0 = ready_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_instr = legal_instr();
      tick();
    end
    in_valid = 1'b0;
    chk("stream_ready_cnt", ready_cnt - rdy0, 32'd10);
    chk("stream_wb_cnt", wb_cnt - wb0, 32'd10);

    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      issue(rand_instr());
    end
    repeat (4) tick();

    wb0  = wb_cnt;
    ill0 = ill_cnt;
    issue(32'h00900293);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("ready_after_midreset", {31'd0, in_ready}, 32'd1);
    repeat (4) tick();
    chk("midreset_no_wb", wb_cnt - wb0, 32'd0);
    chk("midreset_no_ill", ill_cnt - ill0, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("midreset_rf_zero", dbg_data, 32'd0);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, the register and ALU operand width; only 32 is supported.
REQ-002 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  instruction offered.
REQ-006 in_instr  in  32  RV32I instruction word.
REQ-007 in_ready  out  1  sequencer can accept an instruction.
REQ-008 alu_req  out  1  alu_a, alu_b and alu_op are valid this cycle.
REQ-009 alu_a, alu_b  out  32 each  ALU operands.
REQ-010 alu_op  out  4  ALU operation: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9.
REQ-011 alu_result  in  32  combinational ALU result for the current alu_a, alu_b and alu_op.
REQ-012 wb_valid  out  1  one-cycle writeback pulse.
REQ-013 wb_rd  out  5  writeback destination register.
REQ-014 wb_data  out  32  writeback value.
REQ-015 illegal  out  1  one-cycle pulse for a rejected instruction.
REQ-016 dbg_addr  in  5  debug register read address.
REQ-017 dbg_data  out  32  combinational read of register dbg_addr; 0 when dbg_addr is 0.

Function
REQ-018 The block SHALL contain a 32x32 register file, with x0 reading as 0 and never written.
REQ-019 The FSM SHALL have four states: IDLE, DECODE, EXEC, WB.
REQ-020 in_ready SHALL be 1 only in IDLE while reset is low; an instruction is accepted when in_valid and in_ready are both 1 at a clock edge.
REQ-021 On acceptance, the block SHALL latch in_instr and move IDLE->DECODE; otherwise it stays in IDLE.
REQ-022 DECODE SHALL split the instruction into fields: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
REQ-023 In DECODE, R-type instructions (opcode 0110011) SHALL latch A=rf[rs1] and B=rf[rs2].
REQ-024 In DECODE, I-type ALU instructions (opcode 0010011) SHALL latch A=rf[rs1] and B=sign-extended instr[31:20]; for shifts, B=zero-extended instr[24:20].
REQ-025 R-type op mapping SHALL be, by funct3: 000 ADD (funct7=0000000) or SUB (funct7=0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (funct7=0000000) or SRA (funct7=0100000); 110 OR; 111 AND.
REQ-026 For R-type funct3 other than 000 or 101, funct7 SHALL be 0000000.
REQ-027 I-type op mapping SHALL be identical to R-type except: funct3 000 is always ADD; SLLI requires funct7=0000000; SRLI/SRAI are selected by funct7 0000000/0100000.
REQ-028 Any other opcode or funct7 value SHALL be illegal: the block pulses illegal for one cycle in DECODE, returns to IDLE, and performs no ALU request and no writeback.
REQ-029 For a legal instruction, DECODE SHALL go to EXEC.
REQ-030 In EXEC, alu_req SHALL be 1 with the latched operands and op; alu_result is registered at the end of EXEC; then EXEC->WB.
REQ-031 In WB, wb_valid SHALL be 1 with wb_rd=rd and wb_data=registered result, rf[rd] is written at the end of WB when rd!=0, and the FSM returns to IDLE.
REQ-032 Fixed timing SHALL be: accept at edge N; EXEC during cycle N+2; wb_valid during cycle N+3; in_ready high again in cycle N+4. The throughput is one instruction per 4 cycles.
REQ-033 rd=0 SHALL still pulse wb_valid with the computed wb_data, but x0 remains 0.
REQ-034 A register read in DECODE SHALL see all writes from earlier instructions; no bypass is required because WB completes before the next accept.
REQ-035 Outside their active states, alu_a, alu_b, alu_op, wb_rd and wb_data SHALL be 0.
REQ-036 in_instr and in_valid SHALL be ignored outside IDLE.

Reset
REQ-037 While reset is high at a clock edge, the block SHALL: go to IDLE, clear all 32 registers and the latched instruction/operands to 0, and drive 0 on in_ready, alu_req, wb_valid, illegal, alu_a, alu_b, alu_op, wb_rd and wb_data.
REQ-038 Reset asserted mid-operation SHALL abort the in-flight instruction with no writeback and no illegal pulse.
REQ-039 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-040 The bench SHALL cover: ADDI x1,x0,5 (0x00500093) then ADDI x2,x0,-3 (0xFFD00113) -> wb_data 5 then 0xFFFFFFFD; dbg x2=0xFFFFFFFD.
REQ-041 The bench SHALL cover: SUB x3,x1,x2 (0x402081B3) -> alu_op=1, alu_a=5, alu_b=0xFFFFFFFD, wb_rd=3, wb_data=8 in cycle N+3.
REQ-042 The bench SHALL cover: SRAI x4,x2,1 (0x40115213) -> alu_op=7, alu_b=1, wb_data=0xFFFFFFFE; SLLI with funct7=0100000 (0x40111213) -> illegal pulse, no wb_valid, x2 unchanged.
REQ-043 The bench SHALL cover: ADDI x0,x0,7 (0x00700013) -> wb_valid with wb_rd=0, wb_data=7, and dbg x0 reads 0.
REQ-044 The bench SHALL cover: in_valid held high continuously -> in_ready/accept exactly every 4 cycles and no instruction lost.
REQ-045 The bench SHALL cover: reset asserted during EXEC -> no wb_valid, all registers read 0, and in_ready=1 in the cycle after reset deasserts.
